// File: rtl/io_map_pkg.sv
// IO window address map, decode results and request payload for the IO responder.
package io_map_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FC00;
  localparam int unsigned WIN_BITS        = 10;

  localparam logic [WIN_BITS-1:0] OFF_LED   = 10'h060;
  localparam logic [WIN_BITS-1:0] OFF_BLINK = 10'h064;
  localparam logic [WIN_BITS-1:0] OFF_SW    = 10'h070;

  typedef enum logic [2:0] {
    DEC_LED,
    DEC_BLINK,
    DEC_SW,
    DEC_UNMAPPED,
    DEC_OUTSIDE
  } dec_e;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } io_req_t;

  // Misaligned offsets never match a register, so they fall into DEC_UNMAPPED.
  function automatic dec_e decode(input logic [31:0] addr, input logic [31:0] base);
    dec_e d;
    if (addr[31:WIN_BITS] != base[31:WIN_BITS]) begin
      d = DEC_OUTSIDE;
    end else begin
      case (addr[WIN_BITS-1:0])
        OFF_LED:   d = DEC_LED;
        OFF_BLINK: d = DEC_BLINK;
        OFF_SW:    d = DEC_SW;
        default:   d = DEC_UNMAPPED;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/sw_debouncer.sv
// Two-flop synchroniser plus stability counter for the raw switch pins.
module sw_debouncer #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned CYCLES = 20000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);

  localparam int unsigned CNT_W = $clog2(CYCLES + 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt >= CNT_W'(CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/io_responder.sv
// Peripheral end of the CPU IO bus: LED register, debounced switches, 1-cycle read response.
// Optional blink control register at offset 0x064 enabled by IO_LED_BLINK_EN.
module io_responder
  import io_map_pkg::*;
#(
  parameter int unsigned SW_WIDTH        = 16,
  parameter int unsigned LED_WIDTH       = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter logic [31:0] IO_BASE         = IO_BASE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 io_read,
  input  logic                 io_write,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 rdata_valid,
  output logic                 bus_err,
  output logic [LED_WIDTH-1:0] led_out,
  input  logic [SW_WIDTH-1:0]  sw_in
);

  localparam int unsigned PRESC_W = 24;

  io_req_t              req;
  dec_e                 dec;
  logic [SW_WIDTH-1:0]  sw_stable;
  logic [LED_WIDTH-1:0] led_q;
  logic [LED_WIDTH-1:0] led_d;
  logic [LED_WIDTH-1:0] led_mask_d;
  logic [31:0]          rdata_d;
  logic                 valid_d;
  logic                 err_d;
  logic                 blink_q;
  logic                 blink_d;
  logic                 unused_bits;

  assign req         = '{read: io_read, write: io_write, addr: addr, wdata: wdata};
  assign unused_bits = ^req.wdata;

  sw_debouncer #(
    .WIDTH  (SW_WIDTH),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_debouncer (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (sw_in),
    .stable (sw_stable)
  );

`ifdef IO_LED_BLINK_EN
  logic [PRESC_W-1:0] presc_q;
  logic               phase_q;
  logic               phase_d;

  assign phase_d    = phase_q ^ (presc_q == '1);
  assign led_mask_d = {LED_WIDTH{blink_d & phase_d}};

  // Free-running prescaler; phase flips on each wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      phase_q <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      presc_q <= presc_q + PRESC_W'(1);
      phase_q <= phase_d;
      blink_q <= blink_d;
    end
  end
`else
  assign led_mask_d = '0;
  assign blink_q    = 1'b0;
`endif

  // Decode and response; a simultaneous read+write performs the write and flags an error.
  always_comb begin
    dec     = decode(req.addr, IO_BASE);
    led_d   = led_q;
    blink_d = blink_q;
    rdata_d = rdata;
    valid_d = 1'b0;
    err_d   = 1'b0;
`ifndef IO_LED_BLINK_EN
    if (dec == DEC_BLINK) dec = DEC_UNMAPPED;
`endif
    if (dec != DEC_OUTSIDE) begin
      if (req.write) begin
        case (dec)
          DEC_LED:   led_d   = LED_WIDTH'(req.wdata);
          DEC_BLINK: blink_d = req.wdata[0];
          default:   err_d   = 1'b1;
        endcase
        if (req.read) err_d = 1'b1;
      end else if (req.read) begin
        valid_d = 1'b1;
        case (dec)
          DEC_LED:   rdata_d = 32'(led_q);
          DEC_SW:    rdata_d = 32'(sw_stable);
          DEC_BLINK: rdata_d = {31'd0, blink_q};
          default: begin
            rdata_d = '0;
            err_d   = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q       <= '0;
      led_out     <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      led_q       <= led_d;
      led_out     <= led_d ^ led_mask_d;
      rdata       <= rdata_d;
      rdata_valid <= valid_d;
      bus_err     <= err_d;
    end
  end

endmodule
